// File: rtl/piradip_axil_trigger_unit_pkg.sv
// Shared constants for the AXI4-Lite trigger unit.
// Register offsets, ID word, response code and a strobe helper.
package piradip_trigger_pkg;

  localparam int unsigned ID_OFS   = 32'h00;
  localparam int unsigned CTRL_OFS = 32'h04;
  localparam int unsigned SEL_BASE = 32'h08;

  localparam logic [31:0] ID_VALUE  = 32'h5452_4755;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  // Expand a 4-bit byte strobe into a 32-bit byte mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

endpackage

// File: rtl/piradip_axil_trigger_unit_if.sv
// AXI4-Lite bus bundle for the trigger unit.
// master drives requests, slave drives responses.
interface piradip_axil_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/piradip_axil_trigger_unit_regif.sv
// AXI4-Lite subordinate handshake engine.
// Single outstanding write, registered read data.
module piradip_axil_regif
  import piradip_trigger_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  piradip_axil_if.slave         axil,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-3:0] wr_word,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb,
  output logic [ADDR_WIDTH-3:0] rd_word,
  input  logic [31:0]           rd_data
);

  logic aw_held, w_held;
  logic aw_held_n, w_held_n;
  logic bvalid_n, rvalid_n;
  logic aw_fire, w_fire, b_fire;
  logic ar_fire, r_fire;

  assign aw_fire = axil.awvalid && axil.awready;
  assign w_fire  = axil.wvalid && axil.wready;
  assign b_fire  = axil.bvalid && axil.bready;
  assign ar_fire = axil.arvalid && axil.arready;
  assign r_fire  = axil.rvalid && axil.rready;

  assign wr_en   = aw_held && w_held && !axil.bvalid;
  assign rd_word = axil.araddr[ADDR_WIDTH-1:2];

  assign axil.bresp = RESP_OKAY;
  assign axil.rresp = RESP_OKAY;

  // Next-state of the held flags and response valids.
  always_comb begin
    aw_held_n = aw_held;
    w_held_n  = w_held;
    bvalid_n  = axil.bvalid;
    rvalid_n  = axil.rvalid;
    if (aw_fire) aw_held_n = 1'b1;
    if (w_fire)  w_held_n  = 1'b1;
    if (wr_en)   bvalid_n  = 1'b1;
    if (b_fire) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b0;
    end
    if (ar_fire) rvalid_n = 1'b1;
    if (r_fire)  rvalid_n = 1'b0;
  end

  // Handshake state, captured request fields and read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      axil.awready <= 1'b0;
      axil.wready  <= 1'b0;
      axil.bvalid  <= 1'b0;
      axil.arready <= 1'b0;
      axil.rvalid  <= 1'b0;
      axil.rdata   <= '0;
      wr_word      <= '0;
      wr_data      <= '0;
      wr_strb      <= '0;
    end else begin
      aw_held      <= aw_held_n;
      w_held       <= w_held_n;
      axil.awready <= !aw_held_n;
      axil.wready  <= !w_held_n;
      axil.bvalid  <= bvalid_n;
      axil.rvalid  <= rvalid_n;
      axil.arready <= !rvalid_n;
      if (aw_fire) wr_word <= axil.awaddr[ADDR_WIDTH-1:2];
      if (w_fire) begin
        wr_data <= axil.wdata;
        wr_strb <= axil.wstrb;
      end
      if (ar_fire) axil.rdata <= rd_data;
    end
  end

endmodule

// File: rtl/piradip_axil_trigger_unit.sv
// Software trigger generator with per-output routing.
// CTRL writes make a one-cycle pulse, SEL[i] routes it.
module piradip_axil_trigger_unit
  import piradip_trigger_pkg::*;
#(
  parameter int NUM_TRIGGERS = 32,
  parameter int SEL_WIDTH    = 5,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  piradip_axil_if.slave           s_axil,
  output logic [NUM_TRIGGERS-1:0] triggers
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] W_ID   = WW'(ID_OFS / 4);
  localparam logic [WW-1:0] W_CTRL = WW'(CTRL_OFS / 4);
  localparam logic [WW-1:0] W_SEL  = WW'(SEL_BASE / 4);

  logic                    wr_en;
  logic [WW-1:0]           wr_word, rd_word;
  logic [31:0]             wr_data, rd_data;
  logic [3:0]              wr_strb;
  logic [WW-1:0]           w_off, r_off;
  logic                    w_sel_hit, r_sel_hit;
  logic                    ctrl_wr;
  logic [NUM_TRIGGERS-1:0] pulse;
  logic [SEL_WIDTH-1:0]    sel [NUM_TRIGGERS];

  piradip_axil_regif #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regif (
    .clk     (clk),
    .resetn  (resetn),
    .axil    (s_axil),
    .wr_en   (wr_en),
    .wr_word (wr_word),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_word (rd_word),
    .rd_data (rd_data)
  );

  assign w_off     = wr_word - W_SEL;
  assign r_off     = rd_word - W_SEL;
  assign w_sel_hit = (wr_word >= W_SEL)
                  && (32'(w_off) < NUM_TRIGGERS);
  assign r_sel_hit = (rd_word >= W_SEL)
                  && (32'(r_off) < NUM_TRIGGERS);
  assign ctrl_wr   = wr_en && (wr_word == W_CTRL);

  // Read mux; CTRL and unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_word == W_ID)
      rd_data = ID_VALUE;
    else if (r_sel_hit)
      rd_data = 32'(sel[SEL_WIDTH'(r_off)]);
  end

  // Select registers, identity routing out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_TRIGGERS; i++)
        sel[i] <= SEL_WIDTH'(i);
    end else if (wr_en && w_sel_hit && wr_strb[0]) begin
      sel[SEL_WIDTH'(w_off)] <= wr_data[SEL_WIDTH-1:0];
    end
  end

  // One-cycle pulse vector, then routed trigger outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pulse    <= '0;
      triggers <= '0;
    end else begin
      pulse <= ctrl_wr
             ? NUM_TRIGGERS'(wr_data & strb_mask(wr_strb))
             : '0;
      for (int i = 0; i < NUM_TRIGGERS; i++)
        triggers[i] <= pulse[sel[i]];
    end
  end

endmodule

// File: tb/tb_piradip_axil_trigger_unit.sv
// Directed bench for the AXI4-Lite trigger unit.
// Linear steps with hand-computed expectations.
module tb_piradip_axil_trigger_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] triggers;
  int          n_chk = 0;
  int          n_fail = 0;

  piradip_axil_if #(.ADDR_WIDTH(8)) axil ();

  piradip_axil_trigger_unit #(
    .NUM_TRIGGERS (32),
    .SEL_WIDTH    (5),
    .ADDR_WIDTH   (8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_axil   (axil),
    .triggers (triggers)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    bit aw_done, w_done, aw_now, w_now, got;
    aw_done = 0; w_done = 0; got = 0;
    axil.awaddr = a; axil.awvalid = 1'b1;
    axil.wdata = d; axil.wstrb = s; axil.wvalid = 1'b1;
    axil.bready = 1'b1;
    for (int k = 0; k < 20 && !(aw_done && w_done); k++) begin
      @(negedge clk);
      aw_now = axil.awvalid && axil.awready;
      w_now  = axil.wvalid && axil.wready;
      @(posedge clk); #1;
      if (aw_now) begin axil.awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin axil.wvalid = 1'b0;  w_done = 1;  end
    end
    if (!(aw_done && w_done)) tmo("aw_w");
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (axil.bvalid) begin
        got = 1;
        chk("bresp", 32'(axil.bresp), 32'h0);
      end
      @(posedge clk); #1;
    end
    axil.bready = 1'b0;
    if (!got) tmo("bvalid");
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    bit ar_now, ar_done, got;
    ar_done = 0; got = 0; d = 'x; r = 'x;
    axil.araddr = a; axil.arvalid = 1'b1; axil.rready = 1'b1;
    for (int k = 0; k < 20 && !ar_done; k++) begin
      @(negedge clk);
      ar_now = axil.arready;
      @(posedge clk); #1;
      if (ar_now) begin axil.arvalid = 1'b0; ar_done = 1; end
    end
    if (!ar_done) tmo("arready");
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (axil.rvalid) begin
        got = 1; d = axil.rdata; r = axil.rresp;
      end
      @(posedge clk); #1;
    end
    axil.rready = 1'b0;
    if (!got) tmo("rvalid");
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk(tag, d, exp);
  endtask

  task automatic pulse_chk(input string tag, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp);
    axi_write(8'h04, d, s);
    chk(tag, triggers, exp);
    @(posedge clk); #1;
    chk({tag, "_off"}, triggers, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit          got;
    resetn = 1'b0;
    axil.awaddr = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0;
    axil.bready = 1'b0;
    axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(axil.awready), 32'h0);
    chk("rst_arready", 32'(axil.arready), 32'h0);
    chk("rst_bvalid", 32'(axil.bvalid), 32'h0);
    chk("rst_rvalid", 32'(axil.rvalid), 32'h0);
    chk("rst_trig", triggers, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    axi_read(8'h00, d, r);
    chk("id", d, 32'h5452_4755);
    chk("id_resp", 32'(r), 32'h0);
    for (int i = 0; i < 32; i++)
      rd_chk("sel_rst", 8'(8 + 4 * i), 32'(i));

    for (int i = 0; i < 32; i++)
      axi_write(8'(8 + 4 * i), 32'(i), 4'hF);
    pulse_chk("ident_1", 32'h1, 4'hF, 32'h0000_0001);

    for (int i = 0; i < 32; i++)
      axi_write(8'(8 + 4 * i), 32'(31 - i), 4'hF);
    pulse_chk("rev_8001", 32'h8000_0001, 4'hF, 32'h8000_0001);
    pulse_chk("rev_2", 32'h2, 4'hF, 32'h4000_0000);

    for (int i = 0; i < 32; i++)
      axi_write(8'(8 + 4 * i), 32'h3, 4'hF);
    pulse_chk("all3_8", 32'h8, 4'hF, 32'hFFFF_FFFF);
    pulse_chk("all3_7", 32'h7, 4'hF, 32'h0);

    axi_write(8'h18, 32'hFFFF_FFE5, 4'hF);
    rd_chk("sel4_mask", 8'h18, 32'h5);
    rd_chk("ctrl_rd", 8'h04, 32'h0);
    rd_chk("unmap_rd", 8'hFC, 32'h0);
    axi_write(8'hFC, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmap_sel0", 8'h08, 32'h3);
    rd_chk("unmap_id", 8'h00, 32'h5452_4755);
    axi_write(8'h0C, 32'h0, 4'b1110);
    rd_chk("sel1_nostrb", 8'h0C, 32'h3);
    rd_chk("sel_addr_lsb", 8'h0F, 32'h3);
    pulse_chk("ctrl_strb0", 32'h28, 4'b0001, 32'hFFFF_FFFF);
    pulse_chk("ctrl_strb_hi", 32'h28, 4'b1110, 32'h0);

    axil.wdata = 32'h9; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", 32'(axil.wready), 32'h1);
    @(posedge clk); #1;
    axil.wvalid = 1'b0;
    @(posedge clk); #1;
    chk("wfirst_nob", 32'(axil.bvalid), 32'h0);
    axil.awaddr = 8'h1C; axil.awvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_awready", 32'(axil.awready), 32'h1);
    @(posedge clk); #1;
    axil.awvalid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (axil.bvalid) got = 1;
    end
    if (!got) tmo("wfirst_bvalid");
    repeat (3) begin
      @(posedge clk); #1;
      chk("bstall_hold", 32'(axil.bvalid), 32'h1);
    end
    axil.bready = 1'b1;
    @(posedge clk); #1;
    axil.bready = 1'b0;
    chk("bstall_done", 32'(axil.bvalid), 32'h0);
    chk("bstall_awready", 32'(axil.awready), 32'h1);
    rd_chk("wfirst_sel5", 8'h1C, 32'h9);

    axil.araddr = 8'h08; axil.arvalid = 1'b1; axil.rready = 1'b0;
    @(negedge clk);
    chk("rst_ar_ready", 32'(axil.arready), 32'h1);
    @(posedge clk); #1;
    axil.arvalid = 1'b0;
    chk("rst_ar_rvalid", 32'(axil.rvalid), 32'h1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rvalid", 32'(axil.rvalid), 32'h0);
    chk("mid_rst_trig", triggers, 32'h0);
    chk("mid_rst_arready", 32'(axil.arready), 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_sel4", 8'h18, 32'h4);
    rd_chk("post_rst_sel5", 8'h1C, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
